praxos_irq_capture: RTL and testbench
=====================================

// Module: praxos_irq_capture
// PURPOSE
// - Conditions raw interrupt sources into the 32-bit irq_in vector consumed by the Praxos control block (IRQ-in register, port/WB addr 1).
// - Per channel: synchronizer, polarity normalization, then either rising-edge capture into a sticky bit or synchronized level pass-through.
// - Praxos clears sticky bits by writing 1s to port address CLR_ADDR; this block snoops the Praxos port write bus, which the control block ignores at that address.
// PARAMETERS
// - N_IRQ           32            number of source channels, 1..32; irq_in bits [31:N_IRQ] tied 0
// - SYNC_STAGES     2             synchronizer flops per channel, 2..4
// - EDGE_MASK       32'hFFFFFFFF  bit i = 1: channel i is edge/sticky; 0: channel i is level pass-through
// - ACTIVE_LOW_MASK 32'h00000000  bit i = 1: irq_src[i] is inverted before edge/level processing
// - CLR_ADDR        5'd1          Praxos port address decoded for write-1-to-clear
// PORTS
// - clk                  in   1      clock
// - rst_n                in   1      synchronous active-low reset
// - irq_src              in   N_IRQ  raw asynchronous interrupt sources
// - praxos_port_addr     in   5      Praxos port address
// - praxos_port_wr       in   1      Praxos port write strobe, 1 cycle per write
// - praxos_port_wr_data  in   32     Praxos port write data
// - irq_in               out  32     conditioned IRQ vector to the control block, registered
// - irq_overrun          out  32     per-channel overrun flag, registered
// - irq_any              out  1      OR of irq_in, registered
// BEHAVIOUR
// - Reset: rst_n is synchronous, active-low. While rst_n=0: irq_in=0, irq_overrun=0, irq_any=0, all sync flops=0, prev=0, warmup counter=0.
// - Normalize: n[i] = sync_out[i] ^ ACTIVE_LOW_MASK[i]. Sync chain shifts every cycle outside reset.
// - Warmup FSM, states WARM and RUN; WARM on reset.
//   - WARM: counter increments each cycle; prev tracks n; no edges detected.
//   - WARM -> RUN when counter == SYNC_STAGES. RUN holds until the next reset.
//   - An input already active at reset release produces no edge.
// - Edge channel (EDGE_MASK[i]=1), RUN state:
//   - edge[i] = n[i] & ~prev[i]; prev <= n every cycle.
//   - clr[i] = praxos_port_wr & (praxos_port_addr == CLR_ADDR) & praxos_port_wr_data[i].
//   - sticky next = edge ? 1 : (clr ? 0 : sticky). Set wins over a simultaneous clear, so no event is lost.
//   - irq_overrun[i] sets when edge[i] & sticky[i] & ~clr[i], i.e. a new edge arrives while the previous one is still pending.
//   - irq_overrun[i] clears on clr[i], unless it sets in the same cycle.
//   - A held-high input yields one capture only.
// - Level channel (EDGE_MASK[i]=0): irq_in[i] <= n[i] in every state; clr has no effect; irq_overrun[i] = 0 always.
// - Latency, raw source change to irq_in: SYNC_STAGES+1 cycles. This applies to edge capture and to level assertion and deassertion.
// - Clear latency: irq_in bit drops 1 cycle after the clearing write strobe.
// - irq_any updates 1 cycle after irq_in.
// - Write data bits [31:N_IRQ] ignored. Writes to any other address have no effect.
// - Reset mid-operation: all state discarded; the warmup phase repeats.
// - Implementation size: 150-250 lines; generate loop per channel plus shared decode and warmup FSM.
// TESTING
// - irq_src[3] 0->1 after warmup, SYNC_STAGES=2 -> irq_in = 32'h8 exactly 3 cycles later; stays set with the source held; irq_any=1 one cycle after irq_in.
// - Port write addr 1, data 32'h8 -> irq_in[3] = 0 next cycle; write with data 32'h4 instead -> irq_in[3] stays 1.
// - Second rising edge on irq_src[3] while pending -> irq_overrun = 32'h8; write 32'h8 -> irq_in = 0 and irq_overrun = 0.
// - Edge arrives in the same cycle as its clear write -> irq_in[3] = 1 and irq_overrun[3] = 0 afterward.
// - EDGE_MASK = 32'hFFFFFFFE, ACTIVE_LOW_MASK = 32'h1; irq_src[0] 1->0->1:
//   - irq_in[0] follows the inverted level with 3-cycle lag.
//   - A clear write with data 32'h1 has no effect on bit 0.
// - Reset release with irq_src = all 1s, all edge channels:
//   - irq_in stays 0.
//   - Toggling irq_src[7] low then high after warmup -> irq_in = 32'h80.
//   - Asserting rst_n=0 mid-pending -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/praxos_irq_capture.sv
// Praxos interrupt source conditioning: sync, polarity, edge/level capture.
// Sticky edge bits are cleared by snooped write-1-to-clear port writes.
module praxos_irq_capture #(
    parameter int          N_IRQ           = 32,
    parameter int          SYNC_STAGES     = 2,
    parameter logic [31:0] EDGE_MASK       = 32'hFFFF_FFFF,
    parameter logic [31:0] ACTIVE_LOW_MASK = 32'h0000_0000,
    parameter logic [4:0]  CLR_ADDR        = 5'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic [4:0]       praxos_port_addr,
    input  logic             praxos_port_wr,
    input  logic [31:0]      praxos_port_wr_data,
    output logic [31:0]      irq_in,
    output logic [31:0]      irq_overrun,
    output logic             irq_any
);

    typedef enum logic {
        WARM,
        RUN
    } state_t;

    localparam logic [2:0] SYNC_LAST = 3'(SYNC_STAGES);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic        run;
    logic        clr_hit;
    logic [31:0] n;
    logic [31:0] in_d;
    logic [31:0] ov_d;
    logic [31:0] in_q;
    logic [31:0] ov_q;
    logic        any_q;

    // Warmup: ignore edges until every sync chain holds post-reset samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WARM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WARM: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == SYNC_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    assign run     = (state_q == RUN);
    assign clr_hit = praxos_port_wr & (praxos_port_addr == CLR_ADDR);

    for (genvar i = 0; i < 32; i++) begin : g_ch
        if (i < N_IRQ) begin : g_on
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], irq_src[i]};
                end
            end

            assign n[i] = chain_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK[i];
        end else begin : g_off
            assign n[i] = 1'b0;
        end

        if (EDGE_MASK[i]) begin : g_edge
            logic prev_q;
            logic edge_det;
            logic clr;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= n[i];
                end
            end

            assign edge_det = run & n[i] & ~prev_q;
            assign clr      = clr_hit & praxos_port_wr_data[i];
            // A new edge beats a simultaneous clear so no event is lost.
            assign in_d[i]  = edge_det | (in_q[i] & ~clr);
            assign ov_d[i]  = (edge_det & in_q[i] & ~clr)
                            | (ov_q[i] & ~clr);
        end else begin : g_lvl
            assign in_d[i] = n[i];
            assign ov_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q  <= '0;
            ov_q  <= '0;
            any_q <= 1'b0;
        end else begin
            in_q  <= in_d;
            ov_q  <= ov_d;
            any_q <= |in_q;
        end
    end

    assign irq_in      = in_q;
    assign irq_overrun = ov_q;
    assign irq_any     = any_q;

endmodule

// File: tb/tb_praxos_irq_capture.sv
// Scoreboard bench for praxos_irq_capture: history-based reference model,
// directed scenarios followed by randomized sources, writes and resets.
module tb_praxos_irq_capture;

    localparam int          S   = 2;
    localparam logic [31:0] EM  = 32'h7FFF_FFFE;
    localparam logic [31:0] AL  = 32'h0000_0011;
    localparam logic [4:0]  CLR = 5'd1;

    typedef struct {
        logic [31:0] in;
        logic [31:0] ov;
        logic        any;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src_r = '0;
    logic [4:0]  addr_r = '0;
    logic        wr_r = 1'b0;
    logic [31:0] data_r = '0;
    logic [31:0] irq_in;
    logic [31:0] irq_overrun;
    logic        irq_any;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    exp_t        sbq[$];
    exp_t        me;
    logic [31:0] hist[$];
    int          since;
    logic [31:0] m_in;
    logic [31:0] m_ov;
    logic        m_any;
    logic [31:0] n_prev;

    always #5 clk = ~clk;

    praxos_irq_capture #(
        .N_IRQ(32),
        .SYNC_STAGES(S),
        .EDGE_MASK(EM),
        .ACTIVE_LOW_MASK(AL),
        .CLR_ADDR(CLR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .irq_src(src_r),
        .praxos_port_addr(addr_r),
        .praxos_port_wr(wr_r),
        .praxos_port_wr_data(data_r),
        .irq_in(irq_in),
        .irq_overrun(irq_overrun),
        .irq_any(irq_any)
    );

    // One clock cycle of stimulus; the model predicts the outputs that
    // appear after the following rising edge.
    task automatic step(input logic rst, input logic [31:0] src,
                        input logic wr, input logic [4:0] addr,
                        input logic [31:0] data);
        exp_t        e;
        logic [31:0] n;
        logic [31:0] edg;
        logic [31:0] clr;
        logic [31:0] nin;
        logic [31:0] nov;
        @(negedge clk);
        rst_n  = rst;
        src_r  = src;
        wr_r   = wr;
        addr_r = addr;
        data_r = data;
        cyc++;
        if (!rst) begin
            hist.delete();
            repeat (S) hist.push_back('0);
            since  = 0;
            m_in   = '0;
            m_ov   = '0;
            m_any  = 1'b0;
            n_prev = '0;
        end else begin
            // The oldest history entry is what the synchronizers present now.
            n   = hist[0] ^ AL;
            edg = (since > S) ? (n & ~n_prev & EM) : '0;
            clr = (wr && addr == CLR) ? data : '0;
            nin = edg | (m_in & EM & ~clr);
            nov = (edg & m_in & ~clr) | (m_ov & ~clr);
            m_any  = |m_in;
            m_in   = (nin & EM) | (n & ~EM);
            m_ov   = nov & EM;
            n_prev = n;
            since++;
            void'(hist.pop_front());
            hist.push_back(src);
        end
        e.in  = m_in;
        e.ov  = m_ov;
        e.any = m_any;
        e.cyc = cyc;
        sbq.push_back(e);
    endtask

    task automatic idle(input int k, input logic [31:0] src);
        repeat (k) step(1'b1, src, 1'b0, 5'd0, '0);
    endtask

    task automatic clrw(input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] src);
        step(1'b1, src, 1'b1, a, d);
    endtask

    // Monitor: every cycle the DUT presents a fresh output vector.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                me = sbq.pop_front();
                n_cmp++;
                if (irq_in !== me.in) begin
                    n_bad++;
                    $display("FAIL irq_in cyc %0d got %h want %h",
                             me.cyc, irq_in, me.in);
                end
                n_cmp++;
                if (irq_overrun !== me.ov) begin
                    n_bad++;
                    $display("FAIL irq_overrun cyc %0d got %h want %h",
                             me.cyc, irq_overrun, me.ov);
                end
                n_cmp++;
                if (irq_any !== me.any) begin
                    n_bad++;
                    $display("FAIL irq_any cyc %0d got %b want %b",
                             me.cyc, irq_any, me.any);
                end
            end
        end
    end

    logic [31:0] rs;
    logic        rwr;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        rrst;

    initial begin
        repeat (3) step(1'b0, '0, 1'b0, 5'd0, '0);
        idle(6, '0);
        // Edge capture on bit 3, clear, non-matching clear.
        idle(6, 32'h8);
        clrw(5'd1, 32'h8, 32'h8);
        idle(2, 32'h8);
        idle(3, '0);
        idle(5, 32'h8);
        clrw(5'd1, 32'h4, 32'h8);
        clrw(5'd2, 32'h8, 32'h8);
        idle(2, 32'h8);
        // Second edge while pending gives an overrun, then clear both.
        idle(3, '0);
        idle(5, 32'h8);
        clrw(5'd1, 32'h8, 32'h8);
        idle(2, 32'h8);
        // Set pending, then an edge lands in the same cycle as its clear.
        idle(3, '0);
        idle(5, 32'h8);
        idle(3, '0);
        idle(2, 32'h8);
        clrw(5'd1, 32'h8, 32'h8);
        idle(3, 32'h8);
        clrw(5'd1, 32'h8, 32'h8);
        idle(2, '0);
        // Bit 0 is an inverted level channel; clears do not touch it.
        idle(4, 32'h1);
        idle(4, 32'h0);
        clrw(5'd1, 32'h1, 32'h0);
        idle(3, 32'h0);
        idle(4, 32'h1);
        // Reset release with every source high.
        repeat (2) step(1'b0, '1, 1'b0, 5'd0, '0);
        idle(8, '1);
        idle(3, 32'hFFFF_FF7F);
        idle(5, '1);
        step(1'b0, '1, 1'b0, 5'd0, '0);
        idle(6, '1);
        // Randomized traffic.
        rs = '0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                rs = rs ^ (32'h1 << $urandom_range(0, 31));
            end
            if ($urandom_range(0, 19) == 0) begin
                rs = $urandom;
            end
            rwr   = ($urandom_range(0, 5) == 0);
            raddr = $urandom_range(0, 1) ? CLR : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0:       rdata = $urandom;
                1:       rdata = 32'h1 << $urandom_range(0, 31);
                default: rdata = '1;
            endcase
            rrst = ($urandom_range(0, 399) != 0);
            step(rrst, rs, rwr, raddr, rdata);
        end
        idle(2, rs);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain left %0d want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
